// File: rtl/mul_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// mul_pipe_ctrl
//   Sequencer for the 5-stage multiplier pipeline (M1..M5 registers).
//   Tracks a valid bit and ROB index per pipeline slot, drives the per-slot
//   load enables used by the datapath registers, accepts issue through a
//   valid/ready handshake and retires completed ops to the ROB writeback port
//   through a second valid/ready handshake. A flush kills all in-flight ops.
//
//   Build option:
//     MULPIPE_COLLAPSE_EN  defined   -> per-slot bubble collapse. Upstream ops
//                                       advance into empty downstream slots
//                                       while writeback is stalled.
//                          undefined -> lockstep pipeline. A writeback stall
//                                       freezes every slot, bubbles included.
//
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous, active-low reset
//     in_valid     in   issue request (mul op sitting in M1)
//     in_ready     out  slot 0 can load this cycle
//     in_rob_idx   in   ROB index of the issued op
//     flush        in   kill all in-flight ops on this edge
//     stage_en     out  load enable for pipeline register i (combinational)
//     stage_valid  out  slot i holds a live op
//     wb_valid     out  last slot holds a live op
//     wb_ready     in   ROB write port accepts this cycle
//     wb_rob_idx   out  ROB index of the op in the last slot
//     busy         out  any slot live
//     inflight     out  number of live ops (0..STAGES)
//
//   The multiplier datapath registers are free-running cells; they are gated
//   at instantiation with stage_en so data and control advance together.
// ----------------------------------------------------------------------------

// One pipeline slot: valid bit plus ROB index. v_nxt is exported so the
// occupancy counter is computed from exactly the value the slot will load.
module mul_pipe_slot #(
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 v_in,
    input  logic [ROB_IDX_W-1:0] idx_in,
    output logic                 v,
    output logic [ROB_IDX_W-1:0] idx,
    output logic                 v_nxt
);
    // flush only clears the valid bit; the index is a don't-care once v=0
    assign v_nxt = flush ? 1'b0 : (en ? v_in : v);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v   <= 1'b0;
            idx <= '0;
        end else begin
            v <= v_nxt;
            if (en) idx <= idx_in;
        end
    end
endmodule

module mul_pipe_ctrl #(
    parameter  int STAGES    = 5,
    parameter  int ROB_IDX_W = 4,
    localparam int CNT_W     = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROB_IDX_W-1:0] in_rob_idx,
    input  logic                 flush,
    output logic [STAGES-1:0]    stage_en,
    output logic [STAGES-1:0]    stage_valid,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [ROB_IDX_W-1:0] wb_rob_idx,
    output logic                 busy,
    output logic [CNT_W-1:0]     inflight
);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0]                v;
    logic [STAGES-1:0]                v_nxt;
    logic [STAGES-1:0][ROB_IDX_W-1:0] idx;
    logic [STAGES-1:0]                v_in;
    logic [STAGES-1:0][ROB_IDX_W-1:0] idx_in;
    logic [CNT_W-1:0]                 cnt_nxt;

    // ---------------------------------------------------------------- enables
`ifdef MULPIPE_COLLAPSE_EN
    // An op moves when the slot ahead is empty or is itself moving; the last
    // slot moves only when the ROB takes it. Evaluated from the tail forward.
    always_comb begin
        logic [STAGES-1:0] mv;
        mv       = '0;
        mv[LAST] = v[LAST] & wb_ready;
        for (int i = LAST - 1; i >= 0; i--)
            mv[i] = v[i] & (~v[i+1] | mv[i+1]);
        stage_en = ~v | mv;
    end
`else
    // Lockstep: the whole pipe advances unless a live op is stuck at the tail.
    logic adv;
    assign adv      = ~v[LAST] | wb_ready;
    assign stage_en = {STAGES{adv}};
`endif

    assign in_ready = stage_en[0];

    // ------------------------------------------------------------------ slots
    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        if (i == 0) begin : g_head
            // Loading slot 0 without in_valid inserts a bubble.
            assign v_in[i]   = in_valid;
            assign idx_in[i] = in_rob_idx;
        end else begin : g_body
            assign v_in[i]   = v[i-1];
            assign idx_in[i] = idx[i-1];
        end

        mul_pipe_slot #(.ROB_IDX_W(ROB_IDX_W)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .en     (stage_en[i]),
            .flush  (flush),
            .v_in   (v_in[i]),
            .idx_in (idx_in[i]),
            .v      (v[i]),
            .idx    (idx[i]),
            .v_nxt  (v_nxt[i])
        );
    end

    // --------------------------------------------------------------- counters
    // inflight is registered from next-state valids so it always equals
    // popcount of the valid bits it sits beside.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < STAGES; i++)
            cnt_nxt = cnt_nxt + CNT_W'(v_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) inflight <= '0;
        else        inflight <= cnt_nxt;
    end

    // ---------------------------------------------------------------- outputs
    assign stage_valid = v;
    assign wb_valid    = v[LAST];
    assign wb_rob_idx  = idx[LAST];
    assign busy        = |v;

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_pipe_ctrl
//   Directed scenarios followed by a randomized run, every cycle compared with
//   a reference model of slot occupancy kept in plain arrays. Build with
//   +define+MULPIPE_COLLAPSE_EN to exercise the collapsing variant.
// ----------------------------------------------------------------------------
module tb_mul_pipe_ctrl;
    localparam int STAGES = 5;
    localparam int L      = STAGES - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              flush = 1'b0;
    logic              wb_ready = 1'b0;
    logic [3:0]        in_rob_idx = 4'h0;
    logic              in_ready;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic              wb_valid;
    logic [3:0]        wb_rob_idx;
    logic              busy;
    logic [2:0]        inflight;

    mul_pipe_ctrl #(.STAGES(STAGES), .ROB_IDX_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rob_idx  (in_rob_idx),
        .flush       (flush),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rob_idx  (wb_rob_idx),
        .busy        (busy),
        .inflight    (inflight)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which slots hold an op, and that op's ROB index.
    bit   [STAGES-1:0] m_v;
    logic [3:0]        m_idx [STAGES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_v = '0;
        for (int i = 0; i < STAGES; i++) m_idx[i] = 4'h0;
    endfunction

    // Which slots may load this cycle.
    function automatic bit [STAGES-1:0] model_en(input bit wr);
        bit [STAGES-1:0] en;
`ifdef MULPIPE_COLLAPSE_EN
        // A live op can move if there is a hole anywhere ahead of it, or if
        // every slot ahead is full and the tail is draining to the ROB.
        bit hole_ahead;
        hole_ahead = 1'b0;
        for (int i = L; i >= 0; i--) begin
            if (m_v[i]) en[i] = hole_ahead || wr;
            else begin
                en[i]      = 1'b1;
                hole_ahead = 1'b1;
            end
        end
`else
        // Whole pipe freezes only when a live tail op is refused.
        en = (!m_v[L] || wr) ? '1 : '0;
`endif
        return en;
    endfunction

    function automatic void model_edge(input bit iv, input logic [3:0] ii, input bit wr, input bit fl);
        bit   [STAGES-1:0] en;
        bit   [STAGES-1:0] ov;
        logic [3:0]        oi [STAGES];
        en = model_en(wr);
        ov = m_v;
        oi = m_idx;
        if (en[0]) begin
            m_v[0]   = iv;
            m_idx[0] = ii;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (en[i]) begin
                m_v[i]   = ov[i-1];
                m_idx[i] = oi[i-1];
            end
        end
        if (fl) m_v = '0;
    endfunction

    task automatic check_all();
        bit [STAGES-1:0] en;
        en = model_en(wb_ready);
        chk("stage_valid", 32'(stage_valid), 32'(m_v));
        chk("stage_en",    32'(stage_en),    32'(en));
        chk("in_ready",    32'(in_ready),    32'(en[0]));
        chk("wb_valid",    32'(wb_valid),    32'(m_v[L]));
        chk("busy",        32'(busy),        32'(|m_v));
        chk("inflight",    32'(inflight),    32'($countones(m_v)));
        if (m_v[L]) chk("wb_rob_idx", 32'(wb_rob_idx), 32'(m_idx[L]));
    endtask

    // One clock: drive, let combinational outputs settle, compare, clock.
    // Returns 1 time unit after the edge with inputs still applied.
    task automatic cyc(input bit iv, input logic [3:0] ii, input bit wr, input bit fl);
        in_valid   = iv;
        in_rob_idx = ii;
        wb_ready   = wr;
        flush      = fl;
        #2;
        check_all();
        @(posedge clk);
        model_edge(iv, ii, wr, fl);
        #1;
    endtask

    task automatic drain();
        cyc(0, 4'h0, 1, 1);
        cyc(0, 4'h0, 1, 0);
    endtask

    initial begin
        int got_idx [$];
        int got_cyc [$];

        // ---------------- reset state
        model_reset();
        #2;
        chk("rst_stage_valid", 32'(stage_valid), 0);
        chk("rst_wb_valid",    32'(wb_valid),    0);
        chk("rst_wb_rob_idx",  32'(wb_rob_idx),  0);
        chk("rst_busy",        32'(busy),        0);
        chk("rst_inflight",    32'(inflight),    0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- single op, latency 5
        cyc(1, 4'h9, 1, 0);
        for (int k = 1; k < 5; k++) begin
            chk("single_early_wb_valid", 32'(wb_valid), 0);
            cyc(0, 4'h0, 1, 0);
        end
        chk("single_wb_valid_c5", 32'(wb_valid), 1);
        chk("single_wb_idx_c5",   32'(wb_rob_idx), 32'h9);
        cyc(0, 4'h0, 1, 0);
        chk("single_wb_valid_c6", 32'(wb_valid), 0);
        chk("single_inflight_c6", 32'(inflight), 0);

        // ---------------- back-to-back issue
        drain();
        for (int k = 1; k <= 12; k++) begin
            if (k <= 6) cyc(1, 4'(k), 1, 0);
            else        cyc(0, 4'h0, 1, 0);
            if (k <= 6) chk("b2b_in_ready", 32'(in_ready), 1);
            if (wb_valid) begin
                got_idx.push_back(int'(wb_rob_idx));
                got_cyc.push_back(k);
            end
        end
        chk("b2b_count", 32'(got_idx.size()), 6);
        for (int j = 0; j < got_idx.size() && j < 6; j++) begin
            chk("b2b_idx", 32'(got_idx[j]), 32'(j + 1));
            chk("b2b_cyc", 32'(got_cyc[j]), 32'(j + 5));
        end

        // ---------------- writeback stall with a gap between two ops
        drain();
        cyc(1, 4'h7, 1, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(1, 4'h8, 1, 0);
        cyc(0, 4'h0, 1, 0);
        for (int k = 0; k < 4; k++) cyc(0, 4'h0, 0, 0);
        chk("stall_wb_valid", 32'(wb_valid), 1);
        chk("stall_wb_idx",   32'(wb_rob_idx), 32'h7);
`ifdef MULPIPE_COLLAPSE_EN
        chk("stall_stage_valid", 32'(stage_valid), 32'b11000);
        chk("stall_in_ready",    32'(in_ready), 1);
`else
        chk("stall_stage_valid", 32'(stage_valid), 32'b10010);
        chk("stall_in_ready",    32'(in_ready), 0);
`endif

        // ---------------- full pipe, then simultaneous retire + issue
        drain();
        for (int k = 0; k < 5; k++) cyc(1, 4'(10 + k), 0, 0);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_inflight", 32'(inflight), 5);
        cyc(0, 4'h0, 0, 0);
        chk("full_hold_valid", 32'(stage_valid), 32'b11111);
        cyc(1, 4'hF, 1, 0);
        chk("full_swap_inflight", 32'(inflight), 5);
        chk("full_swap_wb_idx",   32'(wb_rob_idx), 32'hB);

        // ---------------- flush beats issue and writeback
        drain();
        for (int k = 0; k < 3; k++) cyc(1, 4'(k + 2), 1, 0);
        cyc(1, 4'hC, 1, 1);
        chk("flush_stage_valid", 32'(stage_valid), 0);
        chk("flush_inflight",    32'(inflight), 0);
        chk("flush_busy",        32'(busy), 0);

        // ---------------- async reset with ops live
        drain();
        for (int k = 0; k < 3; k++) cyc(1, 4'(k + 4), 1, 0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #2;
        model_reset();
        chk("arst_stage_valid", 32'(stage_valid), 0);
        chk("arst_wb_valid",    32'(wb_valid), 0);
        chk("arst_inflight",    32'(inflight), 0);
        chk("arst_busy",        32'(busy), 0);
        reset = 1'b1;
        #1;
        cyc(0, 4'h0, 1, 0);

        // ---------------- randomized traffic
        for (int k = 0; k < 500; k++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
